status_vector_push_arbiter: RTL and testbench

//   Front-end controller for the status value vector (per-entry status_value_logic cells).

---
 rtl/status_vector_push_arbiter_pkg.sv | 4 +
 rtl/status_vector_push_arbiter_rr_arbiter.sv | 28 ++
 rtl/status_vector_push_arbiter.sv | 78 +++++++
 tb/tb_status_vector_push_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/status_vector_push_arbiter_pkg.sv
// status_vector_push_arbiter_pkg: push/pull operation encodings shared with the status vector cells.
package status_vector_push_arbiter_pkg;
  typedef enum logic [1:0] {NN = 2'b00, NP = 2'b01, PN = 2'b10, PP = 2'b11} op_e;
endpackage

// File: rtl/status_vector_push_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from ptr_i.
module rr_arbiter #(
  parameter int REQS = 4,
  localparam int IW = REQS > 1 ? $clog2(REQS) : 1
) (
  input  logic [REQS-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [REQS-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);
  logic          w_found;
  logic [IW-1:0] w_j;
  always_comb begin
    w_found = 1'b0;
    w_j = '0;
    idx_o = '0;
    gnt_o = '0;
    for (int k = 0; k < REQS; k++) begin
      w_j = IW'((int'(ptr_i) + k) % REQS);
      if (!w_found && req_i[w_j]) begin
        w_found = 1'b1;
        idx_o = w_j;
      end
    end
    gnt_o[idx_o] = en_i & w_found;
  end
endmodule

// File: rtl/status_vector_push_arbiter.sv
// status_vector_push_arbiter: round-robin push arbitration, pull acceptance and thermometer valid mask for the status vector.
module status_vector_push_arbiter
  import status_vector_push_arbiter_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4,
  parameter int REQS = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = REQS > 1 ? $clog2(REQS) : 1
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic [REQS-1:0]       req_i,
  input  logic [REQS*WIDTH-1:0] value_i,
  output logic [REQS-1:0]       gnt_o,
  input  logic                  pull_i,
  output logic                  pull_ack_o,
  output logic                  push_o,
  output logic                  pull_o,
  output logic [WIDTH-1:0]      push_value_o,
  output logic [DEPTH-1:0]      update_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CW-1:0]         count_o,
  output logic                  err_o
);
  logic [DEPTH-1:0] r_mask;
  logic [CW-1:0]    r_count;
  logic [IW-1:0]    r_rr;
  logic [REQS-1:0]  r_pend;
  logic             r_err;
  logic             w_push;
  logic [IW-1:0]    w_idx;
  logic [WIDTH-1:0] w_val;
  op_e              w_op;

  assign empty_o = ~r_mask[0];
  assign full_o = r_mask[DEPTH-1];
  assign pull_ack_o = arst_n_i & pull_i & ~empty_o;
  assign pull_o = pull_ack_o;
  assign w_push = arst_n_i & (|req_i) & (~full_o | pull_ack_o);
  assign push_o = w_push;
  assign update_o = r_mask;
  assign count_o = r_count;
  assign err_o = r_err;
  assign w_op = op_e'({w_push, pull_ack_o});
  assign push_value_o = w_val;

  rr_arbiter #(.REQS(REQS)) u_arb (
    .req_i(req_i),
    .ptr_i(r_rr),
    .en_i(w_push),
    .gnt_o(gnt_o),
    .idx_o(w_idx)
  );

  always_comb begin
    w_val = '0;
    for (int r = 0; r < REQS; r++) w_val = w_val | (gnt_o[r] ? value_i[r*WIDTH +: WIDTH] : '0);
  end

  // r_pend remembers requests stalled by a full vector; dropping one before its grant is a protocol error
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_mask <= '0;
      r_count <= '0;
      r_rr <= '0;
      r_pend <= '0;
      r_err <= 1'b0;
    end else begin
      r_mask <= w_op == PN ? {r_mask[DEPTH-2:0], 1'b1} : w_op == NP ? {1'b0, r_mask[DEPTH-1:1]} : r_mask;
      r_count <= w_op == PN ? r_count + CW'(1) : w_op == NP ? r_count - CW'(1) : r_count;
      if (w_push) r_rr <= w_idx == IW'(REQS - 1) ? '0 : w_idx + IW'(1);
      r_pend <= (full_o & ~pull_ack_o) ? req_i : '0;
      r_err <= r_err | (pull_i & empty_o) | (|(r_pend & ~req_i));
    end
  end
endmodule

// File: tb/tb_status_vector_push_arbiter.sv
// tb_status_vector_push_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_status_vector_push_arbiter;
  localparam int DEPTH = 8;
  localparam int WIDTH = 4;
  localparam int REQS = 4;
  localparam int CW = 4;

  logic                  clk_i = 1'b0;
  logic                  arst_n_i = 1'b0;
  logic [REQS-1:0]       req_i = '0;
  logic [REQS*WIDTH-1:0] value_i = '0;
  logic                  pull_i = 1'b0;
  logic [REQS-1:0]       gnt_o;
  logic                  pull_ack_o, push_o, pull_o, empty_o, full_o, err_o;
  logic [WIDTH-1:0]      push_value_o;
  logic [DEPTH-1:0]      update_o;
  logic [CW-1:0]         count_o;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] q[$];
  int               m_rr;
  bit               m_err;
  bit               e_ack, e_push;
  int               e_idx;
  logic [REQS-1:0]  e_gnt;
  logic [WIDTH-1:0] e_val;
  logic [DEPTH-1:0] e_mask;

  status_vector_push_arbiter dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .req_i(req_i), .value_i(value_i), .gnt_o(gnt_o),
    .pull_i(pull_i), .pull_ack_o(pull_ack_o), .push_o(push_o), .pull_o(pull_o),
    .push_value_o(push_value_o), .update_o(update_o), .empty_o(empty_o), .full_o(full_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_eval();
    e_ack = pull_i && q.size() > 0;
    e_push = req_i != 0 && (q.size() < DEPTH || e_ack);
    e_idx = 0;
    for (int k = REQS - 1; k >= 0; k--) if (req_i[(m_rr + k) % REQS]) e_idx = (m_rr + k) % REQS;
    e_gnt = e_push ? REQS'(1 << e_idx) : '0;
    e_val = value_i[e_idx*WIDTH +: WIDTH];
    e_mask = DEPTH'((1 << q.size()) - 1);
  endtask

  task automatic model_commit();
    if (pull_i && q.size() == 0) m_err = 1'b1;
    if (e_ack) void'(q.pop_front());
    if (e_push) begin
      q.push_back(e_val);
      m_rr = (e_idx + 1) % REQS;
    end
  endtask

  task automatic drive(input logic [REQS-1:0] r, input logic [REQS*WIDTH-1:0] v, input logic p);
    @(negedge clk_i);
    req_i = r;
    value_i = v;
    pull_i = p;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_commit();
  endtask

  task automatic do_reset();
    arst_n_i = 1'b0;
    req_i = '0;
    pull_i = 1'b0;
    value_i = '0;
    q.delete();
    m_rr = 0;
    m_err = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #2 arst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (update_o !== 8'h00 || empty_o !== 1'b1 || full_o !== 1'b0 || count_o !== 4'd0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_state got mask=%h empty=%b full=%b count=%0d err=%b exp mask=00 empty=1 full=0 count=0 err=0", update_o, empty_o, full_o, count_o, err_o); end
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 16'($urandom), 1'b0);
      tick();
    end
    #1;
    checks++; if (count_o !== 4'd5 || update_o !== 8'h1F) begin errors++; $display("FAIL reset_pre_count got count=%0d mask=%h exp count=5 mask=1f", count_o, update_o); end
    drive(4'b0001, 16'h1234, 1'b1);
    #2 arst_n_i = 1'b0;
    #1;
    checks++; if (update_o !== 8'h00 || empty_o !== 1'b1 || gnt_o !== 4'b0000 || push_o !== 1'b0 || pull_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL reset_async got mask=%h empty=%b gnt=%b push=%b pull=%b count=%0d exp mask=00 empty=1 gnt=0000 push=0 pull=0 count=0", update_o, empty_o, gnt_o, push_o, pull_o, count_o); end
    q.delete(); m_rr = 0; m_err = 1'b0;
    @(negedge clk_i);
    #2 arst_n_i = 1'b1;
    drive(4'b0001, 16'h0005, 1'b0);
    checks++; if (gnt_o !== 4'b0001 || push_value_o !== 4'h5) begin errors++; $display("FAIL reset_first_grant got gnt=%b val=%h exp gnt=0001 val=5", gnt_o, push_value_o); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 16'($urandom), 1'b0);
      checks++; if (gnt_o !== 4'(1 << (i % 4)) || gnt_o !== e_gnt) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, gnt_o, 4'(1 << (i % 4))); end
      checks++; if (push_value_o !== e_val) begin errors++; $display("FAIL rr_value[%0d] got %h exp %h", i, push_value_o, e_val); end
      tick();
    end
    #1;
    checks++; if (full_o !== 1'b1 || count_o !== 4'd8 || update_o !== 8'hFF) begin errors++; $display("FAIL rr_full got full=%b count=%0d mask=%h exp full=1 count=8 mask=ff", full_o, count_o, update_o); end
  endtask

  task automatic test_full_backpressure();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 16'h0B00, 1'b0);
      checks++; if (gnt_o !== 4'b0000 || push_o !== 1'b0 || count_o !== 4'd8 || err_o !== 1'b0) begin errors++; $display("FAIL full_stall[%0d] got gnt=%b push=%b count=%0d err=%b exp gnt=0000 push=0 count=8 err=0", i, gnt_o, push_o, count_o, err_o); end
      tick();
    end
    drive(4'b0100, 16'h0B00, 1'b1);
    checks++; if (gnt_o !== 4'b0100 || push_o !== 1'b1 || pull_o !== 1'b1 || pull_ack_o !== 1'b1 || push_value_o !== 4'hB) begin errors++; $display("FAIL full_pushpull got gnt=%b push=%b pull=%b ack=%b val=%h exp gnt=0100 push=1 pull=1 ack=1 val=b", gnt_o, push_o, pull_o, pull_ack_o, push_value_o); end
    tick();
    #1;
    checks++; if (count_o !== 4'd8 || full_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL full_after got count=%0d full=%b err=%b exp count=8 full=1 err=0", count_o, full_o, err_o); end
  endtask

  task automatic test_empty_corner();
    do_reset();
    drive(4'b0010, 16'h00A0, 1'b1);
    checks++; if (pull_ack_o !== 1'b0 || push_o !== 1'b1 || push_value_o !== 4'hA || gnt_o !== 4'b0010) begin errors++; $display("FAIL empty_pushpull got ack=%b push=%b val=%h gnt=%b exp ack=0 push=1 val=a gnt=0010", pull_ack_o, push_o, push_value_o, gnt_o); end
    tick();
    #1;
    checks++; if (count_o !== 4'd1 || err_o !== 1'b1 || update_o !== 8'h01) begin errors++; $display("FAIL empty_after got count=%0d err=%b mask=%h exp count=1 err=1 mask=01", count_o, err_o, update_o); end
  endtask

  task automatic test_drain();
    logic [7:0] exp_m [4] = '{8'h03, 8'h01, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, 16'($urandom), 1'b0);
      tick();
    end
    #1;
    checks++; if (update_o !== 8'h07 || err_o !== 1'b0) begin errors++; $display("FAIL drain_start got mask=%h err=%b exp mask=07 err=0", update_o, err_o); end
    for (int k = 0; k < 4; k++) begin
      drive(4'b0000, 16'h0000, 1'b1);
      checks++; if (pull_ack_o !== (k < 3)) begin errors++; $display("FAIL drain_ack[%0d] got %b exp %b", k, pull_ack_o, k < 3); end
      tick();
      #1;
      checks++; if (update_o !== exp_m[k]) begin errors++; $display("FAIL drain_mask[%0d] got %h exp %h", k, update_o, exp_m[k]); end
    end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL drain_err got %b exp 1", err_o); end
  endtask

  task automatic test_random();
    bit [REQS-1:0] pend = '0;
    logic [REQS*WIDTH-1:0] pval = '0;
    int pct;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      for (int r = 0; r < REQS; r++) if (!pend[r] && $urandom_range(1, 0) == 1) begin
        pend[r] = 1'b1;
        pval[r*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      pct = ((i / 1000) % 3 + 1) * 25;
      drive(pend, pval, $urandom_range(99, 0) < pct);
      checks++; if (gnt_o !== e_gnt || $countones(gnt_o) > 1) begin errors++; $display("FAIL rnd_gnt[%0d] got %b exp %b", i, gnt_o, e_gnt); end
      checks++; if (push_o !== e_push || pull_ack_o !== e_ack || pull_o !== e_ack) begin errors++; $display("FAIL rnd_strobe[%0d] got push=%b ack=%b pull=%b exp push=%b ack=%b", i, push_o, pull_ack_o, pull_o, e_push, e_ack); end
      checks++; if (e_push && push_value_o !== e_val) begin errors++; $display("FAIL rnd_value[%0d] got %h exp %h", i, push_value_o, e_val); end
      checks++; if (update_o !== e_mask || count_o !== CW'(q.size()) || count_o !== CW'($countones(update_o))) begin errors++; $display("FAIL rnd_mask[%0d] got mask=%h count=%0d exp mask=%h count=%0d", i, update_o, count_o, e_mask, q.size()); end
      checks++; if (full_o !== (q.size() == DEPTH) || empty_o !== (q.size() == 0) || err_o !== m_err) begin errors++; $display("FAIL rnd_flags[%0d] got full=%b empty=%b err=%b exp full=%b empty=%b err=%b", i, full_o, empty_o, err_o, q.size() == DEPTH, q.size() == 0, m_err); end
      tick();
      if (e_push) pend[e_idx] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full_backpressure();
    test_empty_corner();
    test_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
